// File: rtl/ps2_keyboard_receiver.sv
// Host-side PS/2 receiver: synchronises the keyboard lines, deframes 11-bit
// frames and queues good scan codes in a small FIFO popped with nextdata_n.
module ps2_keyboard_receiver #(
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  // ---------------- synchroniser ----------------
  logic [2:0] cs;
  logic [1:0] ds;
  logic       fall;
  logic       din;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs <= '1;
      ds <= '1;
    end else begin
      cs <= {cs[1:0], ps2_clk};
      ds <= {ds[0], ps2_data};
    end
  end

  assign fall = cs[2] & ~cs[1];
  assign din  = ds[1];

  // ---------------- deframer ----------------
  logic [3:0]        cnt;
  logic [9:0]        frame_buf;
  logic [IDLE_W-1:0] idle_cnt;
  logic              last_bit;
  logic              frame_ok;
  logic              push;
  logic              timeout;

  // din is the stop bit on the final falling edge; it is never stored.
  assign last_bit = fall && (cnt == 4'd10);
  assign frame_ok = ~frame_buf[0] & din & (^frame_buf[9:1]);
  assign push     = last_bit & frame_ok;
  assign timeout  = (idle_cnt == IDLE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idle_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= last_bit & ~frame_ok;
      if (fall) begin
        idle_cnt <= '0;
        cnt      <= (cnt == 4'd10) ? 4'd0 : cnt + 4'd1;
      end else if (cnt == 4'd0) begin
        idle_cnt <= '0;
      end else if (timeout) begin
        // abandon a partial frame silently
        cnt      <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fall && cnt < 4'd10) frame_buf[cnt] <= din;
  end

  // ---------------- FIFO ----------------
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign ready = ~empty;
  assign pop   = ~nextdata_n & ~empty;
  // a same-cycle pop frees the slot the push needs when full
  assign wr_en = push & (~full | pop);
  assign data  = mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[FIFO_AW-1:0]] <= frame_buf[8:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for ps2_keyboard_receiver: vector table, directed corner
// sequences and random frames against a queue-based reference model.
module tb_ps2_keyboard_receiver;

  localparam int TO    = 5000;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  logic [7:0] q[$];
  logic       ov_m = 1'b0;

  ps2_keyboard_receiver #(.FIFO_AW(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // counts high cycles, so a stretched pulse shows up as an extra error
  always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       stop;
    logic       exp_ready;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad_par,
                                           input logic stop);
    return {stop, (~^code) ^ bad_par, code, 1'b0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();
    ov_m = 1'b0;
  endtask

  // Keyboard model: 60 ns bit period; edges kept off clk edges by a 2 ns offset.
  task automatic send_bits(input logic [10:0] f, input int nbits, input bit pop_w);
    @(negedge clk);
    #2;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      #15;
      ps2_clk = 1'b0;
      fork
        begin
          #30;
          ps2_clk = 1'b1;
          #15;
        end
        begin
          if (pop_w && i == 10) begin
            // write lands on the third rising clk edge after the pin fall
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            nextdata_n = 1'b0;
            @(negedge clk);
            nextdata_n = 1'b1;
          end
        end
      join
    end
    ps2_data = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] code, input logic bad_par, input logic stop);
    if (!bad_par && stop) begin
      if (q.size() < DEPTH) q.push_back(code);
      else ov_m = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] code, input logic bad_par, input logic stop);
    send_bits(mk_frame(code, bad_par, stop), 11, 1'b0);
    model_frame(code, bad_par, stop);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_chk(input string name);
    chk({name, ".ready"}, ready, q.size() > 0);
    if (q.size() > 0) chk({name, ".data"}, data, q[0]);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  initial begin
    int f0;
    int nbad;
    logic [7:0] code;
    logic bp, st;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1};
    vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    vecs[3] = '{8'h32, 1'b0, 1'b1, 1'b1, 8'h32, 0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 0};

    do_reset();
    chk("rst.ready", ready, 0);
    chk("rst.overflow", overflow, 0);
    chk("rst.frame_err", frame_err, 0);

    // vector table: one frame each, then drain
    for (int i = 0; i < 8; i++) begin
      f0 = ferr_cnt;
      send(vecs[i].code, vecs[i].bad_par, vecs[i].stop);
      chk($sformatf("vec%0d.ready", i), ready, vecs[i].exp_ready);
      if (vecs[i].exp_ready) chk($sformatf("vec%0d.data", i), data, vecs[i].exp_data);
      chk($sformatf("vec%0d.ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      if (vecs[i].exp_ready) pop_chk($sformatf("vec%0d.pop", i));
      chk($sformatf("vec%0d.empty", i), ready, 0);
    end

    // burst ordering
    send(8'hF0, 0, 1);
    send(8'h1C, 0, 1);
    send(8'h5A, 0, 1);
    pop_chk("burst0");
    pop_chk("burst1");
    pop_chk("burst2");
    chk("burst.empty", ready, 0);

    // overflow: ninth code lost, flag sticky until reset
    do_reset();
    for (int i = 1; i <= 9; i++) send(8'(i), 0, 1);
    chk("ovf.flag", overflow, 1);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("ovf%0d", i));
    chk("ovf.empty", ready, 0);
    pop_chk("ovf.pop_empty");
    chk("ovf.sticky", overflow, 1);
    do_reset();
    chk("ovf.cleared", overflow, 0);

    // bad parity, bad stop, then a good frame
    f0 = ferr_cnt;
    send(8'h1C, 1, 1);
    send(8'h1C, 0, 0);
    chk("bad.ferr", ferr_cnt - f0, 2);
    chk("bad.ready", ready, 0);
    send(8'h32, 0, 1);
    pop_chk("bad.good");

    // timeout recovery from a partial frame
    f0 = ferr_cnt;
    send_bits(mk_frame(8'hAA, 0, 1), 4, 1'b0);
    repeat (TO + 10) @(negedge clk);
    send(8'h45, 0, 1);
    pop_chk("tmo");
    chk("tmo.ferr", ferr_cnt - f0, 0);

    // full FIFO with pop on the push cycle
    do_reset();
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 0, 1);
    send_bits(mk_frame(8'h77, 0, 1), 11, 1'b1);
    void'(q.pop_front());
    q.push_back(8'h77);
    repeat (4) @(negedge clk);
    chk("fullpp.overflow", overflow, 0);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("fullpp%0d", i));
    chk("fullpp.empty", ready, 0);

    // reset asserted during bit 5 of a frame
    f0 = ferr_cnt;
    send_bits(mk_frame(8'h5A, 0, 1), 5, 1'b0);
    ps2_data = 1'b0;
    #15;
    ps2_clk = 1'b0;
    #10;
    rst = 1'b1;
    #20;
    ps2_clk = 1'b1;
    #20;
    rst = 1'b0;
    ps2_data = 1'b1;
    q.delete();
    ov_m = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h29, 0, 1);
    pop_chk("rstmid");
    chk("rstmid.empty", ready, 0);
    chk("rstmid.ferr", ferr_cnt - f0, 0);

    // random frames and pops against the queue model
    do_reset();
    f0 = ferr_cnt;
    nbad = 0;
    for (int i = 0; i < 60; i++) begin
      int r;
      int np;
      code = 8'($urandom);
      r = $urandom_range(0, 9);
      bp = (r == 0);
      st = (r != 1);
      if (bp || !st) nbad++;
      send(code, bp, st);
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) pop_chk($sformatf("rnd%0d.%0d", i, k));
      chk($sformatf("rnd%0d.overflow", i), overflow, ov_m);
    end
    while (q.size() > 0) pop_chk("rnd.drain");
    chk("rnd.empty", ready, 0);
    chk("rnd.ferr", ferr_cnt - f0, nbad);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
